dtcm_icb_arbiter: RTL and testbench

DTCM_ICB_ARBITER -- requirements
Module: dtcm_icb_arbiter

---
 rtl/dtcm_arbt_pkg.sv | 19 +
 rtl/dtcm_icb_arbiter_rr_arb2.sv | 23 ++
 rtl/dtcm_icb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dtcm_icb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtcm_arbt_pkg.sv
// Shared types and default geometry for the DTCM ICB arbiter.
package dtcm_arbt_pkg;

  localparam int unsigned DTCM_AW    = 16;
  localparam int unsigned DTCM_DW    = 32;
  localparam int unsigned DTCM_DEPTH = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAM  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    LSU = 1'b0,
    EXT = 1'b1
  } req_id_e;

endpackage

// File: rtl/dtcm_icb_arbiter_rr_arb2.sv
// Two-way round-robin grant: sole requester wins, a tie goes to the one not granted last.
module dtcm_rr_arb2
  import dtcm_arbt_pkg::*;
(
  input  logic       valid_lsu_i,
  input  logic       valid_ext_i,
  input  req_id_e    last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant, bit 0 = LSU, bit 1 = EXT
  always_comb begin
    grant_o = 2'b00;
    if (valid_lsu_i && valid_ext_i) begin
      grant_o = (last_grant_i == EXT) ? 2'b01 : 2'b10;
    end else if (valid_lsu_i) begin
      grant_o = 2'b01;
    end else if (valid_ext_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/dtcm_icb_arbiter.sv
// Arbitrates the LSU and an external ICB master onto a single-port DTCM SRAM,
// one transaction outstanding at a time.
module dtcm_icb_arbiter
  import dtcm_arbt_pkg::*;
#(
  parameter int unsigned AW    = DTCM_AW,
  parameter int unsigned DW    = DTCM_DW,
  parameter int unsigned DEPTH = DTCM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lsu_icb_cmd_valid,
  output logic                     lsu_icb_cmd_ready,
  input  logic [AW-1:0]            lsu_icb_cmd_addr,
  input  logic                     lsu_icb_cmd_read,
  input  logic [DW-1:0]            lsu_icb_cmd_wdata,
  input  logic [DW/8-1:0]          lsu_icb_cmd_wmask,
  output logic                     lsu_icb_rsp_valid,
  input  logic                     lsu_icb_rsp_ready,
  output logic                     lsu_icb_rsp_err,
  output logic [DW-1:0]            lsu_icb_rsp_rdata,
  input  logic                     ext2dtcm_icb_cmd_valid,
  output logic                     ext2dtcm_icb_cmd_ready,
  input  logic [AW-1:0]            ext2dtcm_icb_cmd_addr,
  input  logic                     ext2dtcm_icb_cmd_read,
  input  logic [DW-1:0]            ext2dtcm_icb_cmd_wdata,
  input  logic [DW/8-1:0]          ext2dtcm_icb_cmd_wmask,
  output logic                     ext2dtcm_icb_rsp_valid,
  input  logic                     ext2dtcm_icb_rsp_ready,
  output logic                     ext2dtcm_icb_rsp_err,
  output logic [DW-1:0]            ext2dtcm_icb_rsp_rdata,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [DW/8-1:0]          ram_wem,
  output logic [DW-1:0]            ram_din,
  input  logic [DW-1:0]            ram_dout
);

  localparam int unsigned RAM_AW     = $clog2(DEPTH);
  localparam int unsigned MW         = DW / 8;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd4;

  arb_state_e        state_q, state_d;
  req_id_e           owner_q, owner_d;
  req_id_e           last_grant_q, last_grant_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;

  logic [1:0]        grant;
  logic              sel_read;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [MW-1:0]     sel_wmask;
  logic              sel_in_range;
  logic              owner_rsp_ready;

  dtcm_rr_arb2 u_rr_arb2 (
    .valid_lsu_i  (lsu_icb_cmd_valid),
    .valid_ext_i  (ext2dtcm_icb_cmd_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Command payload of whichever requester holds the grant
  always_comb begin
    if (grant[1]) begin
      sel_read  = ext2dtcm_icb_cmd_read;
      sel_addr  = ext2dtcm_icb_cmd_addr;
      sel_wdata = ext2dtcm_icb_cmd_wdata;
      sel_wmask = ext2dtcm_icb_cmd_wmask;
    end else begin
      sel_read  = lsu_icb_cmd_read;
      sel_addr  = lsu_icb_cmd_addr;
      sel_wdata = lsu_icb_cmd_wdata;
      sel_wmask = lsu_icb_cmd_wmask;
    end
  end

  assign sel_in_range    = (64'(sel_addr) < ADDR_LIMIT);
  assign owner_rsp_ready = (owner_q == EXT) ? ext2dtcm_icb_rsp_ready : lsu_icb_rsp_ready;

  // Response payload comes straight from the buffer; only rsp_valid is steered
  assign lsu_icb_rsp_rdata      = rdata_q;
  assign lsu_icb_rsp_err        = err_q;
  assign ext2dtcm_icb_rsp_rdata = rdata_q;
  assign ext2dtcm_icb_rsp_err   = err_q;

  // Next-state, handshake and SRAM drive; everything held quiet while rst is high
  always_comb begin
    state_d                = state_q;
    owner_d                = owner_q;
    last_grant_d           = last_grant_q;
    rdata_d                = rdata_q;
    err_d                  = err_q;
    rd_d                   = rd_q;
    lsu_icb_cmd_ready      = 1'b0;
    ext2dtcm_icb_cmd_ready = 1'b0;
    lsu_icb_rsp_valid      = 1'b0;
    ext2dtcm_icb_rsp_valid = 1'b0;
    ram_cs                 = 1'b0;
    ram_we                 = 1'b0;
    ram_addr               = '0;
    ram_wem                = '0;
    ram_din                = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          lsu_icb_cmd_ready      = grant[0];
          ext2dtcm_icb_cmd_ready = grant[1];
          if (|grant) begin
            owner_d      = grant[1] ? EXT : LSU;
            last_grant_d = grant[1] ? EXT : LSU;
            rd_d         = sel_read;
            if (sel_in_range) begin
              ram_cs   = 1'b1;
              ram_we   = ~sel_read;
              ram_addr = sel_addr[RAM_AW+1:2];
              ram_wem  = sel_read ? '0 : sel_wmask;
              ram_din  = sel_wdata;
              err_d    = 1'b0;
              state_d  = RAM;
            end else begin
              err_d   = 1'b1;
              rdata_d = '0;
              state_d = RSP;
            end
          end
        end
        RAM: begin
          rdata_d = rd_q ? ram_dout : '0;
          err_d   = 1'b0;
          state_d = RSP;
        end
        RSP: begin
          lsu_icb_rsp_valid      = (owner_q == LSU);
          ext2dtcm_icb_rsp_valid = (owner_q == EXT);
          if (owner_rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and response buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= LSU;
      last_grant_q <= EXT;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
    end
  end

endmodule

// File: tb/tb_dtcm_icb_arbiter.sv
// Scoreboard bench for dtcm_icb_arbiter with a behavioural single-port SRAM.
module tb_dtcm_icb_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned RAW   = 12;
  localparam int unsigned MW    = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           lsu_icb_cmd_valid = 1'b0;
  logic           lsu_icb_cmd_ready;
  logic [AW-1:0]  lsu_icb_cmd_addr = '0;
  logic           lsu_icb_cmd_read = 1'b0;
  logic [DW-1:0]  lsu_icb_cmd_wdata = '0;
  logic [MW-1:0]  lsu_icb_cmd_wmask = '0;
  logic           lsu_icb_rsp_valid;
  logic           lsu_icb_rsp_ready = 1'b1;
  logic           lsu_icb_rsp_err;
  logic [DW-1:0]  lsu_icb_rsp_rdata;
  logic           ext_cmd_valid = 1'b0;
  logic           ext_cmd_ready;
  logic [AW-1:0]  ext_cmd_addr = '0;
  logic           ext_cmd_read = 1'b0;
  logic [DW-1:0]  ext_cmd_wdata = '0;
  logic [MW-1:0]  ext_cmd_wmask = '0;
  logic           ext_rsp_valid;
  logic           ext_rsp_ready = 1'b1;
  logic           ext_rsp_err;
  logic [DW-1:0]  ext_rsp_rdata;
  logic           ram_cs;
  logic           ram_we;
  logic [RAW-1:0] ram_addr;
  logic [MW-1:0]  ram_wem;
  logic [DW-1:0]  ram_din;
  logic [DW-1:0]  ram_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        ext;
    logic [31:0] rdata;
    logic        err;
    int          hs_cyc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mon_rd;
  logic        mon_er;
  bit          first_seen = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dtcm_icb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .lsu_icb_cmd_valid      (lsu_icb_cmd_valid),
    .lsu_icb_cmd_ready      (lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr       (lsu_icb_cmd_addr),
    .lsu_icb_cmd_read       (lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata      (lsu_icb_cmd_wdata),
    .lsu_icb_cmd_wmask      (lsu_icb_cmd_wmask),
    .lsu_icb_rsp_valid      (lsu_icb_rsp_valid),
    .lsu_icb_rsp_ready      (lsu_icb_rsp_ready),
    .lsu_icb_rsp_err        (lsu_icb_rsp_err),
    .lsu_icb_rsp_rdata      (lsu_icb_rsp_rdata),
    .ext2dtcm_icb_cmd_valid (ext_cmd_valid),
    .ext2dtcm_icb_cmd_ready (ext_cmd_ready),
    .ext2dtcm_icb_cmd_addr  (ext_cmd_addr),
    .ext2dtcm_icb_cmd_read  (ext_cmd_read),
    .ext2dtcm_icb_cmd_wdata (ext_cmd_wdata),
    .ext2dtcm_icb_cmd_wmask (ext_cmd_wmask),
    .ext2dtcm_icb_rsp_valid (ext_rsp_valid),
    .ext2dtcm_icb_rsp_ready (ext_rsp_ready),
    .ext2dtcm_icb_rsp_err   (ext_rsp_err),
    .ext2dtcm_icb_rsp_rdata (ext_rsp_rdata),
    .ram_cs                 (ram_cs),
    .ram_we                 (ram_we),
    .ram_addr               (ram_addr),
    .ram_wem                (ram_wem),
    .ram_din                (ram_din),
    .ram_dout               (ram_dout)
  );

  // Single-port SRAM, read data one cycle after chip select
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < int'(MW); b++) begin
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not reached (cycle %0d)", name, cyc);
  endtask

  // Response monitor: every valid cycle is compared against the head expectation
  always @(negedge clk) begin
    if (!rst && (lsu_icb_rsp_valid || ext_rsp_valid)) begin
      check("rsp_one_owner", 64'(lsu_icb_rsp_valid & ext_rsp_valid), 64'd0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        mon_e  = exp_q[0];
        mon_rd = ext_rsp_valid ? ext_rsp_rdata : lsu_icb_rsp_rdata;
        mon_er = ext_rsp_valid ? ext_rsp_err : lsu_icb_rsp_err;
        check("rsp_owner", 64'(ext_rsp_valid), 64'(mon_e.ext));
        if (!first_seen) begin
          check("rsp_latency", 64'(cyc - mon_e.hs_cyc), 64'(mon_e.lat));
          first_seen = 1'b1;
        end
        check("rsp_rdata", 64'(mon_rd), 64'(mon_e.rdata));
        check("rsp_err", 64'(mon_er), 64'(mon_e.err));
        if ((lsu_icb_rsp_valid && lsu_icb_rsp_ready) || (ext_rsp_valid && ext_rsp_ready)) begin
          void'(exp_q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive_cmd(input logic ext, input logic vld, input logic rd,
                           input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask);
    if (ext) begin
      ext_cmd_valid = vld; ext_cmd_read = rd; ext_cmd_addr = addr;
      ext_cmd_wdata = wdata; ext_cmd_wmask = wmask;
    end else begin
      lsu_icb_cmd_valid = vld; lsu_icb_cmd_read = rd; lsu_icb_cmd_addr = addr;
      lsu_icb_cmd_wdata = wdata; lsu_icb_cmd_wmask = wmask;
    end
  endtask

  // Issue one command, check the SRAM drive in the handshake cycle, queue the response
  task automatic do_cmd(input logic ext, input logic rd, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        input bit push, output int waited);
    bit   done;
    exp_t e;
    done   = 1'b0;
    waited = 0;
    drive_cmd(ext, 1'b1, rd, addr, wdata, wmask);
    while (!done && waited < 40) begin
      @(negedge clk);
      if (ext ? ext_cmd_ready : lsu_icb_cmd_ready) begin
        done = 1'b1;
        check("other_cmd_ready", 64'(ext ? lsu_icb_cmd_ready : ext_cmd_ready), 64'd0);
        check("ram_cs", 64'(ram_cs), 64'(!exp_err));
        if (!exp_err) begin
          check("ram_we", 64'(ram_we), 64'(!rd));
          check("ram_addr", 64'(ram_addr), 64'(addr[13:2]));
          check("ram_wem", 64'(ram_wem), rd ? 64'd0 : 64'(wmask));
          if (!rd) check("ram_din", 64'(ram_din), 64'(wdata));
        end
        if (push) begin
          e = '{ext, exp_rdata, exp_err, cyc, lat};
          exp_q.push_back(e);
        end
      end else begin
        waited++;
      end
    end
    if (!done) fail_now("cmd_handshake_timeout");
    @(posedge clk); #1;
    drive_cmd(ext, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("rsp_timeout");
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lsu_icb_cmd_valid = 1'b1;
    ext_cmd_valid     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_lsu_cmd_ready", 64'(lsu_icb_cmd_ready), 64'd0);
    check("rst_ext_cmd_ready", 64'(ext_cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'({lsu_icb_rsp_valid, ext_rsp_valid}), 64'd0);
    check("rst_ram_cs_we", 64'({ram_cs, ram_we}), 64'd0);
    lsu_icb_cmd_valid = 1'b0;
    ext_cmd_valid     = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    first_seen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   n;
    int   done_cyc;
    logic exp_ext;
    exp_t e;

    do_reset();

    // Basic LSU write then read back
    do_cmd(1'b0, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 1'b1, w);
    wait_idle();
    do_cmd(1'b0, 1'b1, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, w);
    wait_idle();

    // EXT writes and a partial-mask write over an all-ones word
    do_cmd(1'b1, 1'b0, 16'h0020, 32'h12345678, 4'hF, 32'h0, 1'b0, 2, 1'b1, w);
    wait_idle();
    do_cmd(1'b1, 1'b0, 16'h0024, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 2, 1'b1, w);
    wait_idle();
    do_cmd(1'b1, 1'b0, 16'h0024, 32'h00000000, 4'h3, 32'h0, 1'b0, 2, 1'b1, w);
    wait_idle();
    do_cmd(1'b1, 1'b1, 16'h0024, 32'h0, 4'h0, 32'hFFFF0000, 1'b0, 2, 1'b1, w);
    wait_idle();

    // Out-of-range accesses: no SRAM cycle, error one cycle after handshake
    do_cmd(1'b1, 1'b1, 16'h4000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1, w);
    wait_idle();
    do_cmd(1'b0, 1'b0, 16'hFFFC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b1, 1, 1'b1, w);
    wait_idle();
    do_cmd(1'b0, 1'b1, 16'h3FFC, 32'h0, 4'h0, 32'h0, 1'b0, 2, 1'b1, w);
    wait_idle();

    // LSU stalls its response; EXT must wait, then be accepted the cycle after release
    lsu_icb_rsp_ready = 1'b0;
    do_cmd(1'b0, 1'b1, 16'h0020, 32'h0, 4'h0, 32'h12345678, 1'b0, 2, 1'b1, w);
    drive_cmd(1'b1, 1'b1, 1'b1, 16'h0010, 32'h0, 4'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lsu_icb_rsp_valid && n < 10);
    check("stall_rsp_valid", 64'(lsu_icb_rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_rsp_held", 64'(lsu_icb_rsp_valid), 64'd1);
      check("stall_ext_cmd_ready", 64'(ext_cmd_ready), 64'd0);
    end
    @(posedge clk); #1;
    lsu_icb_rsp_ready = 1'b1;
    @(negedge clk);
    check("complete_ext_cmd_ready", 64'(ext_cmd_ready), 64'd0);
    done_cyc = cyc;
    @(negedge clk);
    check("release_ext_cmd_ready", 64'(ext_cmd_ready), 64'd1);
    check("release_ext_cycle", 64'(cyc - done_cyc), 64'd1);
    if (ext_cmd_ready) begin
      e = '{1'b1, 32'hDEADBEEF, 1'b0, cyc, 2};
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    drive_cmd(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    wait_idle();

    // Reset while in RAM discards the response; next command goes straight through
    do_cmd(1'b0, 1'b1, 16'h0010, 32'h0, 4'h0, 32'h0, 1'b0, 2, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ram_rsp_valid", 64'({lsu_icb_rsp_valid, ext_rsp_valid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_cmd(1'b0, 1'b1, 16'h0020, 32'h0, 4'h0, 32'h12345678, 1'b0, 2, 1'b1, w);
    check("post_rst_accept_wait", 64'(w), 64'd0);
    wait_idle();

    // Tie after reset goes to LSU, then grants alternate while both stay valid
    do_reset();
    drive_cmd(1'b0, 1'b1, 1'b1, 16'h0010, 32'h0, 4'h0);
    drive_cmd(1'b1, 1'b1, 1'b1, 16'h0020, 32'h0, 4'h0);
    exp_ext = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(lsu_icb_cmd_ready || ext_cmd_ready) && n < 20);
      check("rr_grant_ext", 64'(ext_cmd_ready), 64'(exp_ext));
      check("rr_grant_lsu", 64'(lsu_icb_cmd_ready), 64'(!exp_ext));
      e = '{exp_ext, exp_ext ? 32'h12345678 : 32'hDEADBEEF, 1'b0, cyc, 2};
      exp_q.push_back(e);
      exp_ext = ~exp_ext;
      if (g < 3) @(posedge clk);
    end
    @(posedge clk); #1;
    drive_cmd(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    drive_cmd(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
